mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified memory port between the core's instruction-fetch port and data-memory port.
//  Sits between minuteCore (imem_*/dmem_* ports) and a single-ported memory.
//  Serialises requests with a fixed-priority-plus-fairness policy and pulses a per-port ready when data returns.
//  Has a watchdog that aborts a transaction the memory never acknowledges.
// PARAMETERS
//  ADDR_W   32  address width, all address ports
//  DATA_W   32  data width, all data ports
//  TIMEOUT  64  cycles in BUSY before abort; 0 disables the watchdog; 1..65535 legal
// PORTS
//  clk            in   1       single clock, all logic on rising edge
//  reset          in   1       synchronous, active-high
//  imem_rd_addr   in   ADDR_W  fetch read address
//  imem_rd_enable in   1       fetch request, level; held until imem_rd_ready
//  imem_rd_data   out  DATA_W  fetch read data, valid while imem_rd_ready=1
//  imem_rd_ready  out  1       one-cycle completion pulse for fetch
//  imem_err       out  1       qualifies imem_rd_ready: transaction timed out
//  dmem_addr      in   ADDR_W  data address
//  dmem_r_enable  in   1       data read request, level
//  dmem_w_enable  in   1       data write request, level; wins over dmem_r_enable
//  dmem_w_data    in   DATA_W  write data
//  dmem_r_data    out  DATA_W  read data, valid while dmem_ready=1 for a read
//  dmem_ready     out  1       one-cycle completion pulse for data port
//  dmem_err       out  1       qualifies dmem_ready: transaction timed out
//  mem_addr       out  ADDR_W  memory address, registered
//  mem_r_enable   out  1       memory read strobe, registered, held through BUSY
//  mem_w_enable   out  1       memory write strobe, registered, held through BUSY
//  mem_w_data     out  DATA_W  memory write data, registered
//  mem_r_data     in   DATA_W  memory read data, sampled when mem_ready=1
//  mem_ready      in   1       memory acknowledge; ignored outside BUSY
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=I, every output 0, watchdog count 0.
//  Reset mid-transaction abandons it; no ready pulse is issued.
//  FSM states: IDLE, BUSY, DONE.
//  IDLE, nothing requested: hold.
//  IDLE, request present: grant, register mem_addr/mem_w_data/strobes, record grant owner, go to BUSY.
//   D = dmem_r_enable | dmem_w_enable.
//   Grant D if D & ~imem_rd_enable.
//   Grant I if imem_rd_enable & ~D.
//   Both pending: grant D unless last_grant==D, then grant I.
//   last_grant updates on every grant.
//  BUSY:
//   Strobes stay asserted; watchdog increments each cycle.
//   On mem_ready=1: capture mem_r_data into the owner's data register, drop strobes next edge, go to DONE.
//   On count==TIMEOUT-1 without mem_ready (TIMEOUT!=0): drop strobes, set owner err, go to DONE.
//   mem_ready and timeout in the same cycle: mem_ready wins, err=0.
//  DONE (1 cycle):
//   Owner ready=1. err as captured. Data holds the captured value (for a write, data = last mem_r_data sample, don't-care).
//   Non-owner ready=0.
//   Next state is IDLE; watchdog clears.
//   An enable still high in the following IDLE is treated as a new request.
//  Timing: minimum latency enable→ready is 3 cycles (IDLE grant, BUSY with mem_ready=1, DONE). Peak throughput is 1 transaction per 3 cycles.
//  Requester dropping enable during BUSY: the transaction still completes and the ready pulse is still issued.
//  dmem_r_enable & dmem_w_enable together: performs the write only.
//  Address/data inputs are sampled only at grant; later changes are ignored.
//  *_rd_data/*_r_data outputs hold their last value outside DONE.
//  Watchdog counter: 16 bits, saturating never reached.
// TESTING
//  1. Fetch only: imem_rd_enable=1, addr 0x100, mem_ready=1 the cycle after grant, mem_r_data=0xDEADBEEF → imem_rd_ready on cycle 3, data 0xDEADBEEF, imem_err=0.
//  2. Contention: fetch and dmem read held continuously → grants alternate D,I,D,I (D first after reset); each ready pulse is exactly 1 cycle.
//  3. Write: dmem_w_enable=1, addr 0x200, w_data 0x55AA → mem_w_enable=1, mem_addr=0x200, mem_w_data=0x55AA held until mem_ready; then dmem_ready pulse.
//  4. Timeout: TIMEOUT=4, mem_ready tied 0 → strobes drop after 4 BUSY cycles; dmem_ready=1 with dmem_err=1; next request is served normally.
//  5. Reset mid-BUSY: reset asserted 1 cycle during BUSY → all outputs 0 at the next edge, no ready pulse; the first grant after reset goes to D when both request.
//  6. Edge cases: r+w simultaneous → write only. mem_ready pulsed in IDLE → ignored. mem_ready and timeout in the same cycle → err=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch (imem) and
// data (dmem) ports. Requests are serialised through IDLE -> BUSY -> DONE. When both
// ports request at once, the data port wins unless it also won the previous grant.
// A watchdog ends a BUSY phase that the memory never acknowledges.
//
// state | meaning
// IDLE  | waiting for a request; a grant latches address, data and strobes
// BUSY  | strobes held toward memory; waiting for mem_ready or watchdog expiry
// DONE  | one-cycle ready pulse (with err) to the port that owned the transaction
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] imem_rd_addr,
    input  logic              imem_rd_enable,
    output logic [DATA_W-1:0] imem_rd_data,
    output logic              imem_rd_ready,
    output logic              imem_err,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic              dmem_r_enable,
    input  logic              dmem_w_enable,
    input  logic [DATA_W-1:0] dmem_w_data,
    output logic [DATA_W-1:0] dmem_r_data,
    output logic              dmem_ready,
    output logic              dmem_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_r_enable,
    output logic              mem_w_enable,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last BUSY count before abort. Unused when TIMEOUT is 0, which disables the watchdog.
    localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
    localparam bit          WD_ON   = (TIMEOUT != 0);

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;   // 1 = data port, 0 = fetch port
    logic        owner;        // same encoding as last_grant
    logic        err_q;
    logic [15:0] wd_count;

    logic req_d;
    logic grant_any;
    logic grant_d;
    logic ack;
    logic timeout;

    // Arbitration, acknowledge and watchdog-expiry decode.
    always_comb begin
        req_d     = dmem_r_enable | dmem_w_enable;
        grant_any = req_d | imem_rd_enable;
        grant_d   = req_d & (~imem_rd_enable | ~last_grant);
        ack       = (state == BUSY) & mem_ready;
        timeout   = WD_ON & (state == BUSY) & ~mem_ready & (wd_count == TO_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any)       state_nxt = BUSY;
            BUSY:    if (ack || timeout)  state_nxt = DONE;
            DONE:                         state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Datapath: latch request at grant, capture read data, run watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant   <= 1'b0;
            owner        <= 1'b0;
            err_q        <= 1'b0;
            wd_count     <= '0;
            mem_addr     <= '0;
            mem_w_data   <= '0;
            mem_r_enable <= 1'b0;
            mem_w_enable <= 1'b0;
            imem_rd_data <= '0;
            dmem_r_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner        <= grant_d;
                        last_grant   <= grant_d;
                        err_q        <= 1'b0;
                        wd_count     <= '0;
                        mem_addr     <= grant_d ? dmem_addr : imem_rd_addr;
                        mem_w_data   <= grant_d ? dmem_w_data : '0;
                        // A simultaneous read and write on the data port performs only the write.
                        mem_w_enable <= grant_d & dmem_w_enable;
                        mem_r_enable <= ~(grant_d & dmem_w_enable);
                    end
                end
                BUSY: begin
                    wd_count <= wd_count + 16'd1;
                    if (ack) begin
                        mem_r_enable <= 1'b0;
                        mem_w_enable <= 1'b0;
                        err_q        <= 1'b0;
                        if (owner) dmem_r_data  <= mem_r_data;
                        else       imem_rd_data <= mem_r_data;
                    end else if (timeout) begin
                        mem_r_enable <= 1'b0;
                        mem_w_enable <= 1'b0;
                        err_q        <= 1'b1;
                    end
                end
                DONE: begin
                    wd_count <= '0;
                end
                default: begin
                    wd_count <= '0;
                end
            endcase
        end
    end

    // Completion pulses go only to the owner, and only during DONE.
    always_comb begin
        imem_rd_ready = (state == DONE) & ~owner;
        dmem_ready    = (state == DONE) & owner;
        imem_err      = imem_rd_ready & err_q;
        dmem_err      = dmem_ready & err_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Uses TIMEOUT=4 so the watchdog can be exercised.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_rd_addr;
    logic        imem_rd_enable;
    logic [31:0] imem_rd_data;
    logic        imem_rd_ready;
    logic        imem_err;
    logic [31:0] dmem_addr;
    logic        dmem_r_enable;
    logic        dmem_w_enable;
    logic [31:0] dmem_w_data;
    logic [31:0] dmem_r_data;
    logic        dmem_ready;
    logic        dmem_err;
    logic [31:0] mem_addr;
    logic        mem_r_enable;
    logic        mem_w_enable;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;
    logic        mem_ready;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_rd_addr  (imem_rd_addr),
        .imem_rd_enable(imem_rd_enable),
        .imem_rd_data  (imem_rd_data),
        .imem_rd_ready (imem_rd_ready),
        .imem_err      (imem_err),
        .dmem_addr     (dmem_addr),
        .dmem_r_enable (dmem_r_enable),
        .dmem_w_enable (dmem_w_enable),
        .dmem_w_data   (dmem_w_data),
        .dmem_r_data   (dmem_r_data),
        .dmem_ready    (dmem_ready),
        .dmem_err      (dmem_err),
        .mem_addr      (mem_addr),
        .mem_r_enable  (mem_r_enable),
        .mem_w_enable  (mem_w_enable),
        .mem_w_data    (mem_w_data),
        .mem_r_data    (mem_r_data),
        .mem_ready     (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        imem_rd_addr   = '0;
        imem_rd_enable = 1'b0;
        dmem_addr      = '0;
        dmem_r_enable  = 1'b0;
        dmem_w_enable  = 1'b0;
        dmem_w_data    = '0;
        mem_r_data     = '0;
        mem_ready      = 1'b0;
        do_reset();

        // Reset state
        chk("rst_mem_r_en", {31'd0, mem_r_enable}, 32'd0);
        chk("rst_mem_w_en", {31'd0, mem_w_enable}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_i_ready",  {31'd0, imem_rd_ready}, 32'd0);
        chk("rst_d_ready",  {31'd0, dmem_ready}, 32'd0);

        // 1. Fetch only, ack on first BUSY cycle
        imem_rd_addr   = 32'h100;
        imem_rd_enable = 1'b1;
        mem_r_data     = 32'hDEADBEEF;
        tick();
        chk("f_mem_r_en", {31'd0, mem_r_enable}, 32'd1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_early_rdy", {31'd0, imem_rd_ready}, 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("f_ready", {31'd0, imem_rd_ready}, 32'd1);
        chk("f_data",  imem_rd_data, 32'hDEADBEEF);
        chk("f_err",   {31'd0, imem_err}, 32'd0);
        chk("f_d_rdy", {31'd0, dmem_ready}, 32'd0);
        chk("f_strobe_drop", {31'd0, mem_r_enable}, 32'd0);
        imem_rd_enable = 1'b0;
        mem_r_data     = 32'h0;
        tick();
        chk("f_ready_off", {31'd0, imem_rd_ready}, 32'd0);
        chk("f_data_hold", imem_rd_data, 32'hDEADBEEF);

        // 2. Contention: D,I,D,I starting from reset
        do_reset();
        imem_rd_addr   = 32'h10;
        dmem_addr      = 32'h20;
        imem_rd_enable = 1'b1;
        dmem_r_enable  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic exp_d;
            exp_d = (i % 2 == 0);
            tick();
            chk($sformatf("c%0d_addr", i), mem_addr, exp_d ? 32'h20 : 32'h10);
            mem_ready  = 1'b1;
            mem_r_data = 32'h1000 + i;
            tick();
            mem_ready = 1'b0;
            chk($sformatf("c%0d_d_rdy", i), {31'd0, dmem_ready}, {31'd0, exp_d});
            chk($sformatf("c%0d_i_rdy", i), {31'd0, imem_rd_ready}, {31'd0, ~exp_d});
            chk($sformatf("c%0d_data", i), exp_d ? dmem_r_data : imem_rd_data, 32'h1000 + i);
            if (i == 3) begin
                imem_rd_enable = 1'b0;
                dmem_r_enable  = 1'b0;
            end
            tick();
            chk($sformatf("c%0d_pulse_d", i), {31'd0, dmem_ready}, 32'd0);
            chk($sformatf("c%0d_pulse_i", i), {31'd0, imem_rd_ready}, 32'd0);
        end

        // 3. Write; inputs changed and enable dropped during BUSY are ignored
        dmem_addr     = 32'h200;
        dmem_w_data   = 32'h55AA;
        dmem_w_enable = 1'b1;
        tick();
        dmem_addr     = 32'h999;
        dmem_w_data   = 32'h1234;
        dmem_w_enable = 1'b0;
        chk("w_w_en",  {31'd0, mem_w_enable}, 32'd1);
        chk("w_r_en",  {31'd0, mem_r_enable}, 32'd0);
        chk("w_addr",  mem_addr, 32'h200);
        chk("w_wdata", mem_w_data, 32'h55AA);
        tick();
        chk("w_hold_en",   {31'd0, mem_w_enable}, 32'd1);
        chk("w_hold_addr", mem_addr, 32'h200);
        chk("w_hold_data", mem_w_data, 32'h55AA);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("w_ready", {31'd0, dmem_ready}, 32'd1);
        chk("w_err",   {31'd0, dmem_err}, 32'd0);
        chk("w_drop",  {31'd0, mem_w_enable}, 32'd0);
        tick();

        // 4. Timeout after 4 BUSY cycles, then normal service
        dmem_addr     = 32'h300;
        dmem_r_enable = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("t_busy4_en", {31'd0, mem_r_enable}, 32'd1);
        chk("t_no_rdy",   {31'd0, dmem_ready}, 32'd0);
        tick();
        dmem_r_enable = 1'b0;
        chk("t_drop",  {31'd0, mem_r_enable}, 32'd0);
        chk("t_ready", {31'd0, dmem_ready}, 32'd1);
        chk("t_err",   {31'd0, dmem_err}, 32'd1);
        tick();
        chk("t_err_off", {31'd0, dmem_err}, 32'd0);
        imem_rd_addr   = 32'h400;
        imem_rd_enable = 1'b1;
        tick();
        chk("t_next_addr", mem_addr, 32'h400);
        mem_ready  = 1'b1;
        mem_r_data = 32'hCAFE;
        tick();
        mem_ready      = 1'b0;
        imem_rd_enable = 1'b0;
        chk("t_next_rdy",  {31'd0, imem_rd_ready}, 32'd1);
        chk("t_next_err",  {31'd0, imem_err}, 32'd0);
        chk("t_next_data", imem_rd_data, 32'hCAFE);
        tick();

        // 5. Reset mid-BUSY; last grant was I, so this grant is D, and D again after reset
        imem_rd_addr   = 32'h500;
        dmem_addr      = 32'h600;
        imem_rd_enable = 1'b1;
        dmem_r_enable  = 1'b1;
        tick();
        chk("r_pre_addr", mem_addr, 32'h600);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r_mem_r_en", {31'd0, mem_r_enable}, 32'd0);
        chk("r_mem_addr", mem_addr, 32'd0);
        chk("r_i_rdy",    {31'd0, imem_rd_ready}, 32'd0);
        chk("r_d_rdy",    {31'd0, dmem_ready}, 32'd0);
        chk("r_i_data",   imem_rd_data, 32'd0);
        tick();
        chk("r_first_d",  mem_addr, 32'h600);
        mem_ready  = 1'b1;
        mem_r_data = 32'h6666;
        tick();
        mem_ready      = 1'b0;
        imem_rd_enable = 1'b0;
        dmem_r_enable  = 1'b0;
        chk("r_d_ready", {31'd0, dmem_ready}, 32'd1);
        tick();

        // 6a. Read and write together: write only
        dmem_addr     = 32'h700;
        dmem_w_data   = 32'hA5A5;
        dmem_r_enable = 1'b1;
        dmem_w_enable = 1'b1;
        tick();
        dmem_r_enable = 1'b0;
        dmem_w_enable = 1'b0;
        chk("rw_w_en", {31'd0, mem_w_enable}, 32'd1);
        chk("rw_r_en", {31'd0, mem_r_enable}, 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("rw_ready", {31'd0, dmem_ready}, 32'd1);
        tick();

        // 6b. mem_ready in IDLE is ignored
        mem_ready  = 1'b1;
        mem_r_data = 32'hBAD0;
        tick();
        mem_ready = 1'b0;
        chk("idle_ack_d", {31'd0, dmem_ready}, 32'd0);
        chk("idle_ack_i", {31'd0, imem_rd_ready}, 32'd0);
        tick();
        chk("idle_ack_d2",  {31'd0, dmem_ready}, 32'd0);
        chk("idle_ack_dat", dmem_r_data, 32'h6666);

        // 6c. mem_ready arrives on the watchdog's last cycle: err stays 0
        dmem_addr     = 32'h800;
        dmem_r_enable = 1'b1;
        tick();
        dmem_r_enable = 1'b0;
        tick();
        tick();
        tick();
        mem_ready  = 1'b1;
        mem_r_data = 32'h7777;
        tick();
        mem_ready = 1'b0;
        chk("race_ready", {31'd0, dmem_ready}, 32'd1);
        chk("race_err",   {31'd0, dmem_err}, 32'd0);
        chk("race_data",  dmem_r_data, 32'h7777);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
